// File: rtl/ahb_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_master
//  Purpose  : Single-outstanding AHB-Lite master. Turns one command at a time
//             into one NONSEQ single transfer and returns a one-cycle response.
//             Illegal (misaligned / bad size) commands never reach the bus.
//             A data-phase wait counter aborts transfers that stall too long.
//  Ports    : AHB_HCLK / AHB_HRESET  - clock, synchronous active-high reset
//             cmd_*                  - command request (valid/ready handshake)
//             rsp_*                  - completion pulse, read data, status
//             AHB_H*                 - AHB-Lite master signals (all registered)
//  Revision : 1.0  initial release
// ============================================================================
module ahb_lite_master #(
   parameter int TIMEOUT_CYCLES = 255   // max data-phase wait cycles (1..1023)
) (
   input  logic        AHB_HCLK,
   input  logic        AHB_HRESET,
   // command side
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   // response side
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   // AHB-Lite master outputs
   output logic [1:0]  AHB_HTRANS,
   output logic [2:0]  AHB_HBURST,
   output logic [3:0]  AHB_HPROT,
   output logic [2:0]  AHB_HSIZE,
   output logic        AHB_HWRITE,
   output logic        AHB_HMASTLOCK,
   output logic [31:0] AHB_HADDR,
   output logic [31:0] AHB_HWDATA,
   output logic        AHB_HSEL,
   // AHB-Lite master inputs
   input  logic [31:0] AHB_HRDATA,
   input  logic        AHB_HREADY,
   input  logic [1:0]  AHB_HRESP
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [9:0] c_timeout   = TIMEOUT_CYCLES[9:0];
   localparam logic [1:0] c_err_okay  = 2'b00;
   localparam logic [1:0] c_err_bus   = 2'b01;
   localparam logic [1:0] c_err_tmo   = 2'b10;
   localparam logic [1:0] c_err_ill   = 2'b11;

   state_t      r_state;
   state_t      w_next_state;

   logic [1:0]  r_htrans;
   logic [2:0]  r_hsize;
   logic        r_hwrite;
   logic [31:0] r_haddr;
   logic [31:0] r_hwdata;
   logic        r_hsel;

   logic [31:0] r_wdata;        // write data held until the data phase
   logic [9:0]  r_wait_cnt;     // DATA cycles seen with HREADY low
   logic        r_err_seen;     // ERROR observed during a wait cycle
   logic [31:0] r_rsp_rdata;
   logic [1:0]  r_rsp_err;

   logic        w_accept;
   logic        w_illegal;
   logic [9:0]  w_wait_next;
   logic        w_timeout;
   logic        w_unused;

   // HRESP[1] is not meaningful on AHB-Lite; only the ERROR bit is used.
   assign w_unused = AHB_HRESP[1];

   assign w_accept    = cmd_valid && (r_state == S_IDLE);
   assign w_illegal   = (cmd_size == 2'b11)
                     || ((cmd_size == 2'b01) && cmd_addr[0])
                     || ((cmd_size == 2'b10) && (cmd_addr[1:0] != 2'b00));
   assign w_wait_next = r_wait_cnt + 10'd1;
   // Timeout fires on the wait cycle that brings the count up to the limit.
   assign w_timeout   = (r_state == S_DATA) && !AHB_HREADY && (w_wait_next == c_timeout);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge AHB_HCLK) begin
      if (AHB_HRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = w_illegal ? S_RESP : S_ADDR;
         S_ADDR: if (AHB_HREADY) w_next_state = S_DATA;
         S_DATA: if (AHB_HREADY || w_timeout) w_next_state = S_RESP;
         S_RESP: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge AHB_HCLK) begin
      if (AHB_HRESET) begin
         r_htrans    <= 2'b00;
         r_hsize     <= 3'b000;
         r_hwrite    <= 1'b0;
         r_haddr     <= 32'h0;
         r_hwdata    <= 32'h0;
         r_hsel      <= 1'b0;
         r_wdata     <= 32'h0;
         r_wait_cnt  <= 10'd0;
         r_err_seen  <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= c_err_okay;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_wdata     <= cmd_wdata;
                  r_rsp_rdata <= 32'h0;
                  r_err_seen  <= 1'b0;
                  if (w_illegal) begin
                     r_rsp_err <= c_err_ill;
                  end else begin
                     r_rsp_err <= c_err_okay;
                     r_htrans  <= 2'b10;
                     r_hsel    <= 1'b1;
                     r_hsize   <= {1'b0, cmd_size};
                     r_haddr   <= cmd_addr;
                     r_hwrite  <= cmd_write;
                  end
               end
            end
            S_ADDR: begin
               if (AHB_HREADY) begin
                  r_htrans   <= 2'b00;
                  r_hsel     <= 1'b0;
                  r_wait_cnt <= 10'd0;
                  if (r_hwrite) r_hwdata <= r_wdata;
               end
            end
            S_DATA: begin
               if (AHB_HREADY) begin
                  if (AHB_HRESP[0] || r_err_seen) begin
                     r_rsp_err <= c_err_bus;
                  end else if (!r_hwrite) begin
                     r_rsp_rdata <= AHB_HRDATA;
                  end
               end else if (w_timeout) begin
                  r_rsp_err <= c_err_tmo;
               end else begin
                  r_wait_cnt <= w_wait_next;
                  if (AHB_HRESP[0]) r_err_seen <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready     = (r_state == S_IDLE);
   assign rsp_valid     = (r_state == S_RESP);
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_err       = r_rsp_err;

   assign AHB_HTRANS    = r_htrans;
   assign AHB_HBURST    = 3'b000;
   assign AHB_HPROT     = 4'b0011;
   assign AHB_HSIZE     = r_hsize;
   assign AHB_HWRITE    = r_hwrite;
   assign AHB_HMASTLOCK = 1'b0;
   assign AHB_HADDR     = r_haddr;
   assign AHB_HWDATA    = r_hwdata;
   assign AHB_HSEL      = r_hsel;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_master
//  Purpose  : Directed self-checking bench for ahb_lite_master. The slave side
//             is driven directly by the stimulus; expected values are written
//             out by hand for each scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_lite_master;

   logic        AHB_HCLK = 1'b0;
   logic        AHB_HRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic [1:0]  AHB_HTRANS;
   logic [2:0]  AHB_HBURST;
   logic [3:0]  AHB_HPROT;
   logic [2:0]  AHB_HSIZE;
   logic        AHB_HWRITE;
   logic        AHB_HMASTLOCK;
   logic [31:0] AHB_HADDR;
   logic [31:0] AHB_HWDATA;
   logic        AHB_HSEL;
   logic [31:0] AHB_HRDATA;
   logic        AHB_HREADY;
   logic [1:0]  AHB_HRESP;

   int n_checks = 0;
   int n_pass   = 0;

   ahb_lite_master #(.TIMEOUT_CYCLES(4)) dut (
      .AHB_HCLK      (AHB_HCLK),
      .AHB_HRESET    (AHB_HRESET),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_size      (cmd_size),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .AHB_HTRANS    (AHB_HTRANS),
      .AHB_HBURST    (AHB_HBURST),
      .AHB_HPROT     (AHB_HPROT),
      .AHB_HSIZE     (AHB_HSIZE),
      .AHB_HWRITE    (AHB_HWRITE),
      .AHB_HMASTLOCK (AHB_HMASTLOCK),
      .AHB_HADDR     (AHB_HADDR),
      .AHB_HWDATA    (AHB_HWDATA),
      .AHB_HSEL      (AHB_HSEL),
      .AHB_HRDATA    (AHB_HRDATA),
      .AHB_HREADY    (AHB_HREADY),
      .AHB_HRESP     (AHB_HRESP)
   );

   always #5 AHB_HCLK = ~AHB_HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge AHB_HCLK);
      #1;
   endtask

   // Present a command for one edge (the accept edge) and withdraw it.
   task automatic issue(input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata);
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_size  = size;
      cmd_wdata = wdata;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      AHB_HRESET = 1'b1;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_addr   = 32'h0;
      cmd_size   = 2'b00;
      cmd_wdata  = 32'h0;
      AHB_HRDATA = 32'h0;
      AHB_HREADY = 1'b1;
      AHB_HRESP  = 2'b00;
      tick();
      tick();

      // ---------------- reset state
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      check("rst_rsp_rdata", rsp_rdata,      32'h0);
      check("rst_htrans",    32'(AHB_HTRANS), 32'd0);
      check("rst_hsel",      32'(AHB_HSEL),   32'd0);
      check("rst_haddr",     AHB_HADDR,       32'h0);
      check("rst_hwdata",    AHB_HWDATA,      32'h0);
      check("rst_hprot",     32'(AHB_HPROT),  32'h3);
      check("rst_hsize",     32'(AHB_HSIZE),  32'd0);
      AHB_HRESET = 1'b0;
      tick();

      // ---------------- word write, zero wait states
      issue(1'b1, 32'h0000_0004, 2'b10, 32'h0000_00A5);
      check("wr_addr_htrans", 32'(AHB_HTRANS), 32'h2);
      check("wr_addr_hsel",   32'(AHB_HSEL),   32'd1);
      check("wr_addr_haddr",  AHB_HADDR,       32'h4);
      check("wr_addr_hwrite", 32'(AHB_HWRITE), 32'd1);
      check("wr_addr_hsize",  32'(AHB_HSIZE),  32'h2);
      check("wr_addr_hburst", 32'(AHB_HBURST), 32'd0);
      check("wr_addr_hprot",  32'(AHB_HPROT),  32'h3);
      check("wr_addr_lock",   32'(AHB_HMASTLOCK), 32'd0);
      check("wr_addr_ready",  32'(cmd_ready),  32'd0);
      tick();
      check("wr_data_htrans", 32'(AHB_HTRANS), 32'd0);
      check("wr_data_hsel",   32'(AHB_HSEL),   32'd0);
      check("wr_data_hwdata", AHB_HWDATA,      32'hA5);
      check("wr_data_rvalid", 32'(rsp_valid),  32'd0);
      tick();
      check("wr_rsp_valid",   32'(rsp_valid),  32'd1);
      check("wr_rsp_err",     32'(rsp_err),    32'd0);
      check("wr_rsp_rdata",   rsp_rdata,       32'h0);
      // command offered alongside rsp_valid must be ignored
      cmd_write = 1'b0; cmd_addr = 32'h0000_0040; cmd_size = 2'b10; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("wr_idle_ready",  32'(cmd_ready),  32'd1);
      check("wr_idle_rvalid", 32'(rsp_valid),  32'd0);
      check("ignored_htrans", 32'(AHB_HTRANS), 32'd0);
      check("ignored_haddr",  AHB_HADDR,       32'h4);

      // ---------------- read with three wait states
      issue(1'b0, 32'h0000_000C, 2'b10, 32'h0);
      check("rd_addr_htrans", 32'(AHB_HTRANS), 32'h2);
      check("rd_addr_hwrite", 32'(AHB_HWRITE), 32'd0);
      check("rd_addr_haddr",  AHB_HADDR,       32'hC);
      tick();                          // now in DATA
      AHB_HREADY = 1'b0;
      tick();
      tick();
      check("rd_wait_rvalid", 32'(rsp_valid),  32'd0);
      check("rd_hwdata_hold", AHB_HWDATA,      32'hA5);
      tick();                          // third wait edge
      check("rd_wait3_rvalid", 32'(rsp_valid), 32'd0);
      AHB_HREADY = 1'b1;
      AHB_HRDATA = 32'h0000_1234;
      tick();                          // sixth edge after accept
      AHB_HRDATA = 32'h0;
      check("rd_rsp_valid",   32'(rsp_valid),  32'd1);
      check("rd_rsp_rdata",   rsp_rdata,       32'h1234);
      check("rd_rsp_err",     32'(rsp_err),    32'd0);
      tick();

      // ---------------- bus error, two-cycle ERROR response
      issue(1'b0, 32'h0000_0010, 2'b10, 32'h0);
      tick();
      AHB_HREADY = 1'b0; AHB_HRESP = 2'b01; AHB_HRDATA = 32'hDEAD_BEEF;
      tick();
      AHB_HREADY = 1'b1;
      tick();
      AHB_HRESP = 2'b00; AHB_HRDATA = 32'h0;
      check("err_rsp_valid",  32'(rsp_valid),  32'd1);
      check("err_rsp_err",    32'(rsp_err),    32'd1);
      check("err_rsp_rdata",  rsp_rdata,       32'h0);
      tick();

      // ---------------- ERROR during wait, OKAY on final cycle
      issue(1'b0, 32'h0000_0014, 2'b10, 32'h0);
      tick();
      AHB_HREADY = 1'b0; AHB_HRESP = 2'b01;
      tick();
      AHB_HREADY = 1'b1; AHB_HRESP = 2'b00; AHB_HRDATA = 32'h5555_AAAA;
      tick();
      AHB_HRDATA = 32'h0;
      check("errmem_valid",   32'(rsp_valid),  32'd1);
      check("errmem_err",     32'(rsp_err),    32'd1);
      check("errmem_rdata",   rsp_rdata,       32'h0);
      tick();

      // ---------------- timeout after exactly 4 wait cycles
      issue(1'b0, 32'h0000_0020, 2'b10, 32'h0);
      tick();                          // DATA
      AHB_HREADY = 1'b0; AHB_HRDATA = 32'hCAFE_0001;
      tick(); tick(); tick();          // three wait edges
      check("tmo_3_rvalid",   32'(rsp_valid),  32'd0);
      tick();                          // fourth wait edge
      check("tmo_rsp_valid",  32'(rsp_valid),  32'd1);
      check("tmo_rsp_err",    32'(rsp_err),    32'd2);
      check("tmo_rsp_rdata",  rsp_rdata,       32'h0);
      check("tmo_rsp_ready",  32'(cmd_ready),  32'd0);
      AHB_HREADY = 1'b1;
      tick();
      AHB_HRDATA = 32'h0;
      check("tmo_idle_ready", 32'(cmd_ready),  32'd1);
      check("tmo_idle_rvld",  32'(rsp_valid),  32'd0);

      // ---------------- illegal commands
      issue(1'b0, 32'h0000_0002, 2'b10, 32'h0);
      check("ill_w_valid",    32'(rsp_valid),  32'd1);
      check("ill_w_err",      32'(rsp_err),    32'd3);
      check("ill_w_htrans",   32'(AHB_HTRANS), 32'd0);
      check("ill_w_hsel",     32'(AHB_HSEL),   32'd0);
      check("ill_w_rdata",    rsp_rdata,       32'h0);
      tick();
      issue(1'b1, 32'h0000_0001, 2'b01, 32'h1111_1111);
      check("ill_h_err",      32'(rsp_err),    32'd3);
      check("ill_h_htrans",   32'(AHB_HTRANS), 32'd0);
      tick();
      issue(1'b0, 32'h0000_0000, 2'b11, 32'h0);
      check("ill_s_err",      32'(rsp_err),    32'd3);
      check("ill_s_valid",    32'(rsp_valid),  32'd1);
      tick();

      // ---------------- legal halfword, byte at odd address
      issue(1'b1, 32'h0000_0102, 2'b01, 32'hBEEF_BEEF);
      check("hw_htrans",      32'(AHB_HTRANS), 32'h2);
      check("hw_hsize",       32'(AHB_HSIZE),  32'h1);
      tick();
      check("hw_hwdata",      AHB_HWDATA,      32'hBEEF_BEEF);
      tick();
      check("hw_err",         32'(rsp_err),    32'd0);
      tick();
      issue(1'b0, 32'h0000_0203, 2'b00, 32'h0);
      check("b_htrans",       32'(AHB_HTRANS), 32'h2);
      check("b_haddr",        AHB_HADDR,       32'h203);
      tick();
      AHB_HRDATA = 32'h7700_0000;
      tick();
      AHB_HRDATA = 32'h0;
      check("b_rdata",        rsp_rdata,       32'h7700_0000);
      tick();

      // ---------------- reset during the data phase
      issue(1'b1, 32'h0000_0030, 2'b10, 32'h1234_5678);
      tick();                          // DATA
      AHB_HREADY = 1'b0;
      tick();                          // still DATA, waiting
      AHB_HRESET = 1'b1;
      tick();
      check("mid_rst_htrans", 32'(AHB_HTRANS), 32'd0);
      check("mid_rst_ready",  32'(cmd_ready),  32'd1);
      check("mid_rst_rvalid", 32'(rsp_valid),  32'd0);
      AHB_HRESET = 1'b0;
      AHB_HREADY = 1'b1;
      tick();
      check("post_rst_rvalid", 32'(rsp_valid), 32'd0);
      check("post_rst_ready",  32'(cmd_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum data-phase wait cycles before abort (range 1..1023).
REQ-002 SHALL have port AHB_HCLK  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port AHB_HRESET  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  block can accept a command.
REQ-006 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-007 SHALL have port cmd_addr  in  32  byte address.
REQ-008 SHALL have port cmd_size  in  2  00=byte, 01=halfword, 10=word; 11 illegal.
REQ-009 SHALL have port cmd_wdata  in  32  write data, already lane-replicated by the requester.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err  out  2  00=OKAY, 01=bus ERROR, 10=timeout, 11=illegal command.
REQ-013 SHALL have outputs AHB_HTRANS[1:0], AHB_HBURST[2:0], AHB_HPROT[3:0], AHB_HSIZE[2:0], AHB_HWRITE, AHB_HMASTLOCK, AHB_HADDR[31:0], AHB_HWDATA[31:0], AHB_HSEL, all registered.
REQ-014 SHALL have inputs AHB_HRDATA[31:0], AHB_HREADY, AHB_HRESP[1:0] (bit0 = ERROR).

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, RESP, with exactly one transfer outstanding and no pipelining.
REQ-016 In IDLE, cmd_ready SHALL be 1; in all other states it SHALL be 0.
REQ-017 A command SHALL be accepted on an edge with cmd_valid & cmd_ready; the block SHALL latch addr, size, write and wdata.
REQ-018 Illegal command (size 11, halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL drive no bus cycle: go to RESP, rsp_err=11.
REQ-019 Legal command SHALL go to ADDR, driving HTRANS=10 (NONSEQ), HSEL=1, HBURST=000, HPROT=0011, HMASTLOCK=0, HSIZE={0,size}, HADDR, HWRITE.
REQ-020 ADDR SHALL hold its outputs until an edge with HREADY=1, then go to DATA.
REQ-021 On entering DATA, HTRANS SHALL be 00 and HSEL 0; HWDATA SHALL equal the latched wdata for a write, otherwise it holds.
REQ-022 DATA SHALL end on an edge with HREADY=1: HRDATA is captured (reads only) and HRESP[0] is recorded; the block then goes to RESP.
REQ-023 An HRESP ERROR seen with HREADY=0 SHALL be remembered, so rsp_err=01 even if the final-cycle HRESP is OKAY.
REQ-024 A wait counter SHALL count DATA cycles with HREADY=0; reaching TIMEOUT_CYCLES SHALL force RESP with rsp_err=10, ignoring any later HREADY.
REQ-025 The counter SHALL clear on each entry to DATA and never wrap.
REQ-026 RESP SHALL last one cycle with rsp_valid=1, then go to IDLE; rsp_valid has no backpressure.
REQ-027 rsp_rdata SHALL be 0 for writes, errors, timeouts and illegal commands.
REQ-028 Minimum latency SHALL be: accept edge N, ADDR cycle N+1, DATA cycle N+2, rsp_valid in cycle N+3, cmd_ready again in cycle N+4.
REQ-029 cmd_valid SHALL be ignored outside IDLE, including cmd_valid asserted in the same cycle as rsp_valid.

Reset
REQ-030 While AHB_HRESET=1 at an edge, the FSM SHALL go to IDLE.
REQ-031 While AHB_HRESET=1 at an edge, outputs SHALL become: cmd_ready=1, rsp_valid=0, rsp_err=00, rsp_rdata=0, HTRANS=00, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=000, HBURST=000, HPROT=0011, HMASTLOCK=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no rsp_valid.

Verification
REQ-033 Bench SHALL cover: write addr 0x0000_0004, data 0x0000_00A5, word, HREADY always 1 -> HTRANS=10 for one cycle, HWDATA=0xA5 next cycle, rsp_valid 3 cycles after accept, rsp_err=00.
REQ-034 Bench SHALL cover: read 0x0000_000C, slave inserts 3 wait states, HRDATA=0x0000_1234 -> rsp_rdata=0x1234, rsp_valid 6 cycles after accept.
REQ-035 Bench SHALL cover: read with HRESP=01/HREADY=0 then HRESP=01/HREADY=1 -> rsp_err=01, rsp_rdata=0.
REQ-036 Bench SHALL cover: TIMEOUT_CYCLES=4, HREADY held 0 in data phase -> rsp_err=10 after exactly 4 wait cycles; cmd_ready returns the cycle after rsp_valid.
REQ-037 Bench SHALL cover: word command at addr 0x0000_0002 -> HTRANS stays 00, rsp_err=11 one cycle after accept.
REQ-038 Bench SHALL cover: AHB_HRESET asserted during DATA -> next cycle HTRANS=00, cmd_ready=1, no rsp_valid.
